// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg                                                              |
// | Shared types and derived constants for the 7-segment scan blocks.    |
// | Rev 1.0 - initial parametrised scanner release                       |
// +----------------------------------------------------------------------+
package seg_pkg;

  // Slot phases: blank guard, anode window, blank guard around each digit
  typedef enum logic [1:0] {
    SET  = 2'd0,
    PRE  = 2'd1,
    ON   = 2'd2,
    POST = 2'd3
  } seg_state_t;

  // Length of the anode window in ticks for a given brightness width
  function automatic int on_len(input int bright_w);
    return (1 << bright_w) - 1;
  endfunction

  // Total ticks per digit slot: SET + PRE + ON window + POST
  function automatic int slot_ticks(input int bright_w);
    return on_len(bright_w) + 3;
  endfunction

  // Digit index width, never narrower than one bit
  function automatic int digit_idx_w(input int num_digits);
    return (num_digits > 2) ? $clog2(num_digits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_gen                                                             |
// | Clock-enable generator: one-clk tick every TICK_DIV clks while en=1. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int                 c_DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_LAST  = c_DIV_W'(TICK_DIV - 1);

  logic [c_DIV_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_LAST);
  assign tick      = en & w_at_last;

  // Free-running divider, held at zero while stopped so a restart is a full period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!en || w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_ctrl                                                        |
// | Guarded-slot 7-segment anode scanner with PWM brightness, per-digit  |
// | enable mask, run/stop control and a frame-done strobe.               |
// | Rev 1.0 - initial parametrised scanner release                       |
// +----------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CHAR_W     = 4,
  parameter int TICK_DIV   = 100000,
  parameter int BRIGHT_W   = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [NUM_DIGITS-1:0]               digit_en,
  input  logic [BRIGHT_W-1:0]                 bright,
  input  logic [NUM_DIGITS*CHAR_W-1:0]        chars,
  output logic [NUM_DIGITS-1:0]               an,
  output logic [CHAR_W-1:0]                   char,
  output logic [digit_idx_w(NUM_DIGITS)-1:0]  digit_idx,
  output logic                                frame_done
);

  localparam int                     c_IDX_W     = digit_idx_w(NUM_DIGITS);
  localparam int                     c_ON_LEN    = on_len(BRIGHT_W);
  localparam logic [BRIGHT_W-1:0]    c_ON_LAST   = BRIGHT_W'(c_ON_LEN - 1);
  localparam logic [c_IDX_W-1:0]     c_TOP_DIGIT = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0]  c_AN_OFF    = {NUM_DIGITS{1'b1}};

  seg_state_t            r_state, w_state_nxt;
  logic [c_IDX_W-1:0]    r_d, w_d_nxt;
  logic [BRIGHT_W-1:0]   r_on_cnt, w_on_cnt_nxt;
  logic [BRIGHT_W-1:0]   r_bright_q, w_bright_q_nxt;
  logic [NUM_DIGITS-1:0] r_an, w_an_nxt;
  logic [CHAR_W-1:0]     r_char, w_char_nxt;
  logic [c_IDX_W-1:0]    r_digit_idx, w_digit_idx_nxt;
  logic                  r_frame_done, w_frame_done_nxt;

  logic                  w_tick;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic [BRIGHT_W-1:0]   w_on_inc;
  logic [CHAR_W-1:0]     w_char_arr [NUM_DIGITS];

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (w_tick)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_char_slice
    assign w_char_arr[gi] = chars[gi*CHAR_W +: CHAR_W];
  end

  assign w_an_sel = ~(NUM_DIGITS'(1) << r_d);
  assign w_on_inc = r_on_cnt + BRIGHT_W'(1);

  // Next-state and next-output logic; everything advances only on a tick
  always_comb begin
    w_state_nxt      = r_state;
    w_d_nxt          = r_d;
    w_on_cnt_nxt     = r_on_cnt;
    w_bright_q_nxt   = r_bright_q;
    w_an_nxt         = r_an;
    w_char_nxt       = r_char;
    w_digit_idx_nxt  = r_digit_idx;
    w_frame_done_nxt = 1'b0;

    if (!en) begin
      // Stopped: blank and rewind to the top digit; char/digit_idx hold
      w_state_nxt  = SET;
      w_d_nxt      = c_TOP_DIGIT;
      w_on_cnt_nxt = '0;
      w_an_nxt     = c_AN_OFF;
    end else if (w_tick) begin
      case (r_state)
        SET: begin
          w_an_nxt        = c_AN_OFF;
          w_char_nxt      = w_char_arr[r_d];
          w_digit_idx_nxt = r_d;
          w_state_nxt     = PRE;
        end
        PRE: begin
          w_bright_q_nxt = bright;
          w_on_cnt_nxt   = '0;
          w_an_nxt       = (digit_en[r_d] && (bright != '0)) ? w_an_sel : c_AN_OFF;
          w_state_nxt    = ON;
        end
        ON: begin
          w_on_cnt_nxt = w_on_inc;
          // Anode has been low for bright_q ticks once this tick lands
          if (w_on_inc == r_bright_q) begin
            w_an_nxt = c_AN_OFF;
          end
          if (r_on_cnt == c_ON_LAST) begin
            w_an_nxt     = c_AN_OFF;
            w_on_cnt_nxt = '0;
            w_state_nxt  = POST;
          end
        end
        POST: begin
          w_d_nxt          = (r_d == '0) ? c_TOP_DIGIT : r_d - c_IDX_W'(1);
          w_frame_done_nxt = (r_d == '0);
          w_state_nxt      = SET;
        end
        default: begin
          w_an_nxt    = c_AN_OFF;
          w_state_nxt = SET;
        end
      endcase
    end
  end

  // Scan state and digit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SET;
      r_d     <= c_TOP_DIGIT;
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
    end
  end

  // PWM counter, sampled brightness and registered pin outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_on_cnt     <= '0;
      r_bright_q   <= '0;
      r_an         <= c_AN_OFF;
      r_char       <= '0;
      r_digit_idx  <= c_TOP_DIGIT;
      r_frame_done <= 1'b0;
    end else begin
      r_on_cnt     <= w_on_cnt_nxt;
      r_bright_q   <= w_bright_q_nxt;
      r_an         <= w_an_nxt;
      r_char       <= w_char_nxt;
      r_digit_idx  <= w_digit_idx_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign an         = r_an;
  assign char       = r_char;
  assign digit_idx  = r_digit_idx;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_scan_ctrl                                                     |
// | Scoreboard bench for seg_scan_ctrl (4 digits, TICK_DIV=4, ON_LEN=7). |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  digit_en;
  logic [2:0]  bright;
  logic [15:0] chars;
  logic [3:0]  an;
  logic [3:0]  char_out;
  logic [1:0]  digit_idx;
  logic        frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .CHAR_W     (4),
    .TICK_DIV   (4),
    .BRIGHT_W   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_en   (digit_en),
    .bright     (bright),
    .chars      (chars),
    .an         (an),
    .char       (char_out),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] an;
    logic [3:0] ch;
    logic [1:0] idx;
    int         start;
    int         low;
  } slot_t;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] ch;
  } sc_t;

  slot_t obs_q[$], exp_q[$];
  sc_t   sc_q[$], sc_exp_q[$];
  int    fd_q[$], fd_exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int overlap_err = 0;

  slot_t      cur;
  bit         in_low = 1'b0;
  logic [5:0] last_sc = '0;

  // Monitor: turns anode activity, frame strobes and char changes into records
  always @(negedge clk) begin
    if (an !== 4'hF) begin
      if (!in_low) begin
        in_low    = 1'b1;
        cur.an    = an;
        cur.ch    = char_out;
        cur.idx   = digit_idx;
        cur.start = cyc;
        cur.low   = 0;
      end
      if (an !== cur.an || $countones(~an) != 1) overlap_err++;
      cur.low++;
    end else if (in_low) begin
      in_low = 1'b0;
      obs_q.push_back(cur);
    end
    if (frame_done === 1'b1) fd_q.push_back(cyc);
    if ({digit_idx, char_out} !== last_sc) begin
      sc_q.push_back('{idx: digit_idx, ch: char_out});
      last_sc = {digit_idx, char_out};
    end
  end

  task automatic clear_queues();
    obs_q.delete(); exp_q.delete();
    sc_q.delete();  sc_exp_q.delete();
    fd_q.delete();  fd_exp_q.delete();
  endtask

  task automatic do_reset(input logic [2:0] b, input logic [3:0] de,
                          input logic [15:0] ch, output int c0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; bright = b; digit_en = de; chars = ch;
    repeat (3) @(negedge clk);
    #1;
    clear_queues();
    rst = 1'b1;
    c0  = cyc;
  endtask

  task automatic push_slot(input int d, input int start, input int low);
    logic [3:0] a;
    a = 4'b0001 << d;
    exp_q.push_back('{an: ~a, ch: 4'(d), idx: 2'(d), start: start, low: low});
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_sc(input int n, input int budget);
    for (int i = 0; i < budget && sc_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_fd(input int n, input int budget);
    for (int i = 0; i < budget && fd_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] v, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (an === v) hit = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; bright = 3'd7; digit_en = 4'hF; chars = 16'h3210;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("FAIL reset_an: got %b want 1111", an); end
    n_cmp++;
    if (char_out !== 4'h0) begin n_err++; $display("FAIL reset_char: got %h want 0", char_out); end
    n_cmp++;
    if (digit_idx !== 2'd3) begin n_err++; $display("FAIL reset_idx: got %0d want 3", digit_idx); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd: got %b want 0", frame_done); end
  endtask

  task automatic test_full_bright();
    int c0;
    slot_t e, o;
    do_reset(3'd7, 4'hF, 16'h3210, c0);
    for (int i = 0; i < 8; i++) push_slot(3 - (i % 4), c0 + 8 + 40*i, 28);
    fd_exp_q.push_back(c0 + 160);
    fd_exp_q.push_back(c0 + 320);
    wait_obs(8, 400);
    wait_fd(2, 100);
    n_cmp++;
    if (obs_q.size() < 8) begin n_err++; $display("FAIL full_count: got %0d slots want 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o.an !== e.an || o.ch !== e.ch || o.idx !== e.idx || o.start != e.start || o.low != e.low) begin
        n_err++;
        $display("FAIL full_slot: got an=%b ch=%h idx=%0d start=%0d low=%0d want an=%b ch=%h idx=%0d start=%0d low=%0d",
                 o.an, o.ch, o.idx, o.start, o.low, e.an, e.ch, e.idx, e.start, e.low);
      end
    end
    n_cmp++;
    if (fd_q.size() < 2) begin n_err++; $display("FAIL full_fd_count: got %0d want 2", fd_q.size()); end
    while (fd_exp_q.size() > 0 && fd_q.size() > 0) begin
      int fe, fo;
      fe = fd_exp_q.pop_front(); fo = fd_q.pop_front();
      n_cmp++;
      if (fo != fe) begin n_err++; $display("FAIL full_fd_time: got %0d want %0d", fo, fe); end
    end
  endtask

  task automatic test_low_bright();
    int c0;
    slot_t e, o;
    sc_t se, so;
    do_reset(3'd2, 4'hF, 16'h3210, c0);
    for (int i = 0; i < 4; i++) push_slot(3 - i, c0 + 8 + 40*i, 8);
    wait_obs(4, 200);
    n_cmp++;
    if (obs_q.size() < 4) begin n_err++; $display("FAIL dim_count: got %0d slots want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o.an !== e.an || o.ch !== e.ch || o.start != e.start || o.low != e.low) begin
        n_err++;
        $display("FAIL dim_slot: got an=%b ch=%h start=%0d low=%0d want an=%b ch=%h start=%0d low=%0d",
                 o.an, o.ch, o.start, o.low, e.an, e.ch, e.start, e.low);
      end
    end

    do_reset(3'd0, 4'hF, 16'hA5C7, c0);
    sc_exp_q.push_back('{idx: 2'd3, ch: 4'hA});
    sc_exp_q.push_back('{idx: 2'd2, ch: 4'h5});
    sc_exp_q.push_back('{idx: 2'd1, ch: 4'hC});
    sc_exp_q.push_back('{idx: 2'd0, ch: 4'h7});
    wait_sc(4, 200);
    while (cyc < c0 + 170) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL dark_an: got %0d lit slots want 0", obs_q.size()); end
    n_cmp++;
    if (sc_q.size() < 4) begin n_err++; $display("FAIL dark_scan_count: got %0d want 4", sc_q.size()); end
    while (sc_exp_q.size() > 0 && sc_q.size() > 0) begin
      se = sc_exp_q.pop_front(); so = sc_q.pop_front();
      n_cmp++;
      if (so.idx !== se.idx || so.ch !== se.ch) begin
        n_err++;
        $display("FAIL dark_scan: got idx=%0d ch=%h want idx=%0d ch=%h", so.idx, so.ch, se.idx, se.ch);
      end
    end
  endtask

  task automatic test_mask();
    int c0;
    slot_t e, o;
    do_reset(3'd7, 4'b1010, 16'h3210, c0);
    for (int i = 0; i < 4; i++) push_slot((i % 2 == 0) ? 3 : 1, c0 + 8 + 80*i, 28);
    fd_exp_q.push_back(c0 + 160);
    fd_exp_q.push_back(c0 + 320);
    wait_obs(4, 400);
    wait_fd(2, 100);
    n_cmp++;
    if (obs_q.size() != 4) begin n_err++; $display("FAIL mask_count: got %0d slots want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o.an !== e.an || o.start != e.start || o.low != e.low) begin
        n_err++;
        $display("FAIL mask_slot: got an=%b start=%0d low=%0d want an=%b start=%0d low=%0d",
                 o.an, o.start, o.low, e.an, e.start, e.low);
      end
    end
    while (fd_exp_q.size() > 0) begin
      int fe, fo;
      fe = fd_exp_q.pop_front();
      fo = (fd_q.size() > 0) ? fd_q.pop_front() : -1;
      n_cmp++;
      if (fo != fe) begin n_err++; $display("FAIL mask_fd_time: got %0d want %0d", fo, fe); end
    end
  endtask

  task automatic test_char_midslot();
    int c0;
    bit hit;
    sc_t se, so;
    do_reset(3'd7, 4'hF, 16'h3210, c0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (digit_idx === 2'd2) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL mid_wait: got no digit 2 want digit 2 within 100 clks"); end
    @(negedge clk);
    chars = 16'h3910;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (char_out !== 4'h2) begin n_err++; $display("FAIL mid_hold: got %h want 2", char_out); end
    sc_exp_q.push_back('{idx: 2'd3, ch: 4'h3});
    sc_exp_q.push_back('{idx: 2'd2, ch: 4'h2});
    sc_exp_q.push_back('{idx: 2'd1, ch: 4'h1});
    sc_exp_q.push_back('{idx: 2'd0, ch: 4'h0});
    sc_exp_q.push_back('{idx: 2'd3, ch: 4'h3});
    sc_exp_q.push_back('{idx: 2'd2, ch: 4'h9});
    wait_sc(6, 300);
    n_cmp++;
    if (sc_q.size() < 6) begin n_err++; $display("FAIL mid_count: got %0d want 6", sc_q.size()); end
    while (sc_exp_q.size() > 0 && sc_q.size() > 0) begin
      se = sc_exp_q.pop_front(); so = sc_q.pop_front();
      n_cmp++;
      if (so.idx !== se.idx || so.ch !== se.ch) begin
        n_err++;
        $display("FAIL mid_scan: got idx=%0d ch=%h want idx=%0d ch=%h", so.idx, so.ch, se.idx, se.ch);
      end
    end
  endtask

  task automatic test_en_drop();
    int c0;
    bit hit;
    slot_t e, o;
    do_reset(3'd7, 4'hF, 16'h3210, c0);
    wait_an(4'b1101, 200, hit);
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL en_wait: got no an=1101 want an=1101 within 200 clks"); end
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("FAIL en_off_an: got %b want 1111", an); end
    n_cmp++;
    if (digit_idx !== 2'd1 || char_out !== 4'h1) begin
      n_err++; $display("FAIL en_off_hold: got idx=%0d ch=%h want idx=1 ch=1", digit_idx, char_out);
    end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL en_off_fd: got %b want 0", frame_done); end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("FAIL en_stopped_an: got %b want 1111", an); end
    #1;
    clear_queues();
    en = 1'b1;
    c0 = cyc;
    push_slot(3, c0 + 8, 28);
    wait_obs(1, 100);
    n_cmp++;
    if (obs_q.size() < 1) begin
      n_err++; $display("FAIL en_restart: got 0 slots want 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.an !== e.an || o.ch !== e.ch || o.start != e.start || o.low != e.low) begin
        n_err++;
        $display("FAIL en_restart: got an=%b ch=%h start=%0d low=%0d want an=%b ch=%h start=%0d low=%0d",
                 o.an, o.ch, o.start, o.low, e.an, e.ch, e.start, e.low);
      end
    end
  endtask

  task automatic test_rst_midslot();
    int c0;
    bit hit;
    slot_t e, o;
    do_reset(3'd7, 4'hF, 16'h3210, c0);
    wait_an(4'b1101, 200, hit);
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL rst_wait: got no an=1101 want an=1101 within 200 clks"); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("FAIL rst_async_an: got %b want 1111", an); end
    n_cmp++;
    if (digit_idx !== 2'd3 || char_out !== 4'h0) begin
      n_err++; $display("FAIL rst_async_regs: got idx=%0d ch=%h want idx=3 ch=0", digit_idx, char_out);
    end
    @(negedge clk);
    #1;
    clear_queues();
    rst = 1'b1;
    c0  = cyc;
    push_slot(3, c0 + 8, 28);
    wait_obs(1, 100);
    n_cmp++;
    if (obs_q.size() < 1) begin
      n_err++; $display("FAIL rst_resume: got 0 slots want 1");
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.an !== e.an || o.start != e.start || o.low != e.low) begin
        n_err++;
        $display("FAIL rst_resume: got an=%b start=%0d low=%0d want an=%b start=%0d low=%0d",
                 o.an, o.start, o.low, e.an, e.start, e.low);
      end
    end
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (frame_done === 1'b1) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL rst_fd_wait: got no frame_done want pulse within 300 clks"); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_async_fd: got %b want 0", frame_done); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Watchdog so a stuck scan still ends the run
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_bright();
    test_low_bright();
    test_mask();
    test_char_midslot();
    test_en_drop();
    test_rst_midslot();
    n_cmp++;
    if (overlap_err != 0) begin n_err++; $display("FAIL one_anode: got %0d violations want 0", overlap_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
